// File: rtl/div_unit_pkg.sv
// div_unit_pkg: definitions shared by the iterative divider and the CPU
// control logic. Holds the divider FSM encoding and the iteration count.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one radix-2 restoring iteration, purely combinational.
// Shifts the partial remainder left, bringing in the next dividend bit,
// trial-subtracts the divisor magnitude, and restores if the result is negative.
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before this iteration
//   msb_in               next dividend bit, MSB first
//   divisor  [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after this iteration
//   q_bit                quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, msb_in};
        // One extra bit above the remainder so the borrow shows up as a sign bit.
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for MIPS DIV/DIVU. One quotient bit
// per clock. The quotient goes to LO and the remainder goes to HI.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   DIV_IDLE | waiting for start
//   DIV_RUN  | iterating, cnt_q = 0..DIV_ITERS-1
//   DIV_DONE | results valid, done high for this one cycle
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   start                request, sampled only when not busy
//   is_signed            1 = DIV, 0 = DIVU (captured with start)
//   dividend, divisor    rs / rt operands (captured with start)
//   busy                 division in progress
//   done                 one-cycle completion pulse
//   q, r                 quotient / remainder, held until the next completion
//   div_zero             last completed operation had divisor == 0
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = $clog2(DIV_ITERS);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] qmag, rmag;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .msb_in  (quo_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        dividend_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
        divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
        qmag         = {quo_q[WIDTH-2:0], step_qbit};
        rmag         = step_rem[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        zero_d     = zero_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                if (start) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dividend_mag;
                    dvs_d   = divisor_mag;
                    neg_q_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d = is_signed & dividend[WIDTH-1];
                    zero_d  = (divisor == '0);
                end else if (state_q == DIV_DONE) begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = qmag;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_ITERS - 1)) begin
                    state_d = DIV_DONE;
                    // Divide by zero leaves an all-ones quotient whatever the signs.
                    q_d = (neg_q_q && !zero_q) ? (~qmag + WIDTH'(1)) : qmag;
                    r_d = neg_r_q ? (~rmag + WIDTH'(1)) : rmag;
                    div_zero_d = zero_q;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            zero_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            zero_q     <= zero_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == DIV_RUN);
    assign done     = (state_q == DIV_DONE);
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics from plain integer arithmetic.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eq, output logic [31:0] er,
                                    output logic ez);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
            ez = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            eq = lq[31:0];
            er = lr[31:0];
            ez = 1'b0;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
    endfunction

    // Issues one request and waits for done; checks busy width and latency.
    task automatic do_op(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez);
        int lat;
        int busy_cnt;
        int both;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        lat = 0; busy_cnt = 0; both = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy && done) both = 1;
        chk({name, " latency"}, lat + 1, 33);
        chk({name, " busy_cycles"}, busy_cnt, 32);
        chk({name, " busy_and_done"}, both, 0);
        chk({name, " q"}, q, eq);
        chk({name, " r"}, r, er);
        chk({name, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    endtask

    initial begin
        vec_t vt[10];
        logic [31:0] eq, er;
        logic ez;
        int cyc;
        int seen;

        vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vt[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vt[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vt[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        vt[5] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vt[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vt[7] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vt[8] = '{1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vt[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset q", q, 32'd0);
        chk("reset r", r, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive entries are issued back-to-back from the DONE cycle.
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].eq, vt[i].er, vt[i].ez);
        end

        // done is a single-cycle pulse; results hold afterwards.
        @(posedge clk); #1;
        chk("done pulse width", {31'd0, done}, 32'd0);
        chk("hold q", q, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("hold r", r, 32'd0);

        // start while busy is ignored; input changes during RUN do not matter.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd20; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0; dividend = 32'd77; divisor = 32'd11;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd99; divisor = 32'd9;
        @(negedge clk);
        start = 1'b0; dividend = 32'd1234; divisor = 32'd5; is_signed = 1'b1;
        cyc = 0;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("ignore-start done seen", {31'd0, done}, 32'd1);
        chk("ignore-start q", q, 32'd6);
        chk("ignore-start r", r, 32'd2);
        @(posedge clk); #1;
        chk("ignore-start no second done", {31'd0, done}, 32'd0);
        repeat (33) @(posedge clk);
        #1;
        chk("ignore-start stays idle", {31'd0, busy | done}, 32'd0);

        // rst mid-RUN aborts without a done pulse or result update.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-abort busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort q", q, 32'd0);
        chk("abort r", r, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort no done in 40", seen, 0);

        // rst together with start: the request is dropped.
        start = 1'b1; rst = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst+start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst+start still idle", {31'd0, busy}, 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                4: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            ref_div(s, a, b, eq, er, ez);
            if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
            do_op($sformatf("rnd%0d s=%0d %08h/%08h", i, s, a, b), s, a, b, eq, er, ez);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
